// File: rtl/rvfi_check_pkg.sv
// Shared definitions for the rvfi_*_check family: error codes reported on
// fail_code and the helper that sizes the reorder-window index.
package rvfi_check_pkg;

  localparam int ORDER_W = 64;
  localparam int CODE_W  = 3;

  typedef enum logic [CODE_W-1:0] {
    ERR_NONE     = 3'd0,
    ERR_MISMATCH = 3'd1,
    ERR_DUP      = 3'd2,
    ERR_WINDOW   = 3'd3,
    ERR_ALIGN    = 3'd4
  } fail_code_t;

  // Bits needed to index a window of 'depth' slots (never below 1).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rvfi_order_buffer.sv
// Reorder window storage. Each slot holds one retired instruction, indexed by
// the low bits of its rvfi_order. The read side exposes up to NRET consecutive
// occupied slots starting at base_i; every exposed entry is freed at the next
// edge. occ_o reports occupancy with those entries already freed so that a
// slot drained and re-captured on the same edge is seen as available.
module rvfi_order_buffer
  import rvfi_check_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NRET  = 1,
  parameter  int DEPTH = 8,
  localparam int IW    = idx_width(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IW-1:0]        base_i,
  input  logic [NRET-1:0]      we_i,
  input  logic [NRET*IW-1:0]   waddr_i,
  input  logic [NRET*XLEN-1:0] wpc_rdata_i,
  input  logic [NRET*XLEN-1:0] wpc_wdata_i,
  input  logic [NRET-1:0]      wintr_i,
  output logic [NRET-1:0]      rd_vld_o,
  output logic [NRET*XLEN-1:0] rd_pc_rdata_o,
  output logic [NRET*XLEN-1:0] rd_pc_wdata_o,
  output logic [NRET-1:0]      rd_intr_o,
  output logic [DEPTH-1:0]     occ_o
);

  logic [DEPTH-1:0] occ_q, occ_d;
  logic [DEPTH-1:0] free_mask;
  logic [DEPTH-1:0] intr_q;
  logic [XLEN-1:0]  rdata_q [DEPTH];
  logic [XLEN-1:0]  wdata_q [DEPTH];
  logic [IW-1:0]    rd_slot [NRET];
  logic             run;

  // In-order read chain: stop at the first empty slot after base_i.
  always_comb begin
    run           = 1'b1;
    free_mask     = '0;
    rd_vld_o      = '0;
    rd_pc_rdata_o = '0;
    rd_pc_wdata_o = '0;
    rd_intr_o     = '0;
    for (int k = 0; k < NRET; k++) begin
      rd_slot[k] = base_i + IW'(k);
      if (run && (k < DEPTH) && occ_q[rd_slot[k]]) begin
        rd_vld_o[k]                    = 1'b1;
        rd_pc_rdata_o[k*XLEN +: XLEN]  = rdata_q[rd_slot[k]];
        rd_pc_wdata_o[k*XLEN +: XLEN]  = wdata_q[rd_slot[k]];
        rd_intr_o[k]                   = intr_q[rd_slot[k]];
        free_mask[rd_slot[k]]          = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  assign occ_o = occ_q & ~free_mask;

  // Next occupancy: drained slots freed first, then new captures set.
  always_comb begin
    occ_d = occ_o;
    for (int i = 0; i < NRET; i++) begin
      if (we_i[i]) begin
        occ_d[waddr_i[i*IW +: IW]] = 1'b1;
      end
    end
  end

  // Occupancy bits clear asynchronously so stale entries are never drained.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Payload storage; contents are only meaningful while the slot is occupied.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NRET; i++) begin
      if (we_i[i]) begin
        rdata_q[waddr_i[i*IW +: IW]] <= wpc_rdata_i[i*XLEN +: XLEN];
        wdata_q[waddr_i[i*IW +: IW]] <= wpc_wdata_i[i*XLEN +: XLEN];
        intr_q[waddr_i[i*IW +: IW]]  <= wintr_i[i];
      end
    end
  end

endmodule

// File: rtl/rvfi_pc_order_check.sv
// PC-continuity checker for an RVFI trace whose NRET channels may retire out
// of order inside a DEPTH-instruction window. Retirements are parked in the
// order buffer, drained strictly by rvfi_order, and each drained pc_rdata is
// compared with the pc_wdata of the instruction before it. The first error is
// latched on fail/fail_code/fail_order until reset.
module rvfi_pc_order_check
  import rvfi_check_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NRET   = 1,
  parameter int DEPTH  = 8,
  parameter int IALIGN = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NRET-1:0]          rvfi_valid,
  input  logic [NRET*64-1:0]       rvfi_order,
  input  logic [NRET*XLEN-1:0]     rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]     rvfi_pc_wdata,
  input  logic [NRET-1:0]          rvfi_intr,
  output logic                     fail,
  output logic [2:0]               fail_code,
  output logic [63:0]              fail_order,
  output logic [31:0]              checked_cnt,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int IW = idx_width(DEPTH);
  localparam int PW = IW + 1;

  // Misaligned target PC for the configured instruction alignment.
  function automatic logic misaligned(input logic [XLEN-1:0] pc);
    return (IALIGN == 16) ? pc[0] : (pc[1:0] != 2'b00);
  endfunction

  logic [63:0]      exp_order_q, exp_order_d;
  logic [XLEN-1:0]  last_wdata_q, last_wdata_d;
  logic             have_prev_q, have_prev_d;
  logic             fail_q, fail_d;
  fail_code_t       code_q, code_d;
  logic [63:0]      ford_q, ford_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [PW-1:0]    pend_q, pend_d;

  logic [NRET-1:0]      we;
  logic [NRET*IW-1:0]   waddr;
  logic [NRET-1:0]      rd_vld;
  logic [NRET*XLEN-1:0] rd_pc_rdata;
  logic [NRET*XLEN-1:0] rd_pc_wdata;
  logic [NRET-1:0]      rd_intr;
  logic [DEPTH-1:0]     occ_avail;

  logic [63:0]      ch_order [NRET];
  logic [IW-1:0]    ch_slot  [NRET];
  fail_code_t       ch_code  [NRET];
  logic [NRET-1:0]  ch_dup;
  logic [NRET-1:0]  ch_beyond;

  logic [PW-1:0]    n_drain, n_cap;
  logic             drn_err, cap_err, err_now;
  logic [63:0]      drn_order, cap_order, err_order;
  fail_code_t       cap_code, err_code;

  rvfi_order_buffer #(
    .XLEN  (XLEN),
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i         (clock),
    .rst_ni        (reset),
    .base_i        (exp_order_q[IW-1:0]),
    .we_i          (we),
    .waddr_i       (waddr),
    .wpc_rdata_i   (rvfi_pc_rdata),
    .wpc_wdata_i   (rvfi_pc_wdata),
    .wintr_i       (rvfi_intr),
    .rd_vld_o      (rd_vld),
    .rd_pc_rdata_o (rd_pc_rdata),
    .rd_pc_wdata_o (rd_pc_wdata),
    .rd_intr_o     (rd_intr),
    .occ_o         (occ_avail)
  );

  // Drain: walk the in-order chain, check continuity, advance the window.
  always_comb begin
    last_wdata_d = last_wdata_q;
    have_prev_d  = have_prev_q;
    n_drain      = '0;
    drn_err      = 1'b0;
    drn_order    = '0;
    for (int k = 0; k < NRET; k++) begin
      if (rd_vld[k]) begin
        if (have_prev_d && !rd_intr[k] && !drn_err &&
            (rd_pc_rdata[k*XLEN +: XLEN] != last_wdata_d)) begin
          drn_err   = 1'b1;
          drn_order = exp_order_q + 64'(k);
        end
        last_wdata_d = rd_pc_wdata[k*XLEN +: XLEN];
        have_prev_d  = 1'b1;
        n_drain      = n_drain + PW'(1);
      end
    end
    exp_order_d = exp_order_q + 64'(n_drain);
  end

  // Split the flat channel buses into per-channel order and slot index.
  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      ch_order[i] = rvfi_order[i*64 +: 64];
      ch_slot[i]  = rvfi_order[i*64 +: IW];
    end
  end

  // Capture: classify each channel against the post-drain window and occupancy.
  always_comb begin
    we        = '0;
    waddr     = '0;
    ch_dup    = '0;
    ch_beyond = '0;
    n_cap     = '0;
    cap_err   = 1'b0;
    cap_code  = ERR_NONE;
    cap_order = '0;
    for (int i = 0; i < NRET; i++) begin
      ch_code[i] = ERR_NONE;
      waddr[i*IW +: IW] = ch_slot[i];
      ch_dup[i] = (ch_order[i] < exp_order_d) || occ_avail[ch_slot[i]];
      for (int j = 0; j < i; j++) begin
        if ((rvfi_valid[j] && (ch_order[j] == ch_order[i])) ||
            (we[j] && (ch_slot[j] == ch_slot[i]))) begin
          ch_dup[i] = 1'b1;
        end
      end
      ch_beyond[i] = ({1'b0, ch_order[i]} >= ({1'b0, exp_order_d} + 65'(DEPTH)));
      if (rvfi_valid[i]) begin
        if (ch_dup[i]) begin
          ch_code[i] = ERR_DUP;
        end else if (ch_beyond[i]) begin
          ch_code[i] = ERR_WINDOW;
        end else begin
          we[i] = 1'b1;
          n_cap = n_cap + PW'(1);
          if (misaligned(rvfi_pc_wdata[i*XLEN +: XLEN])) begin
            ch_code[i] = ERR_ALIGN;
          end
        end
        if ((ch_code[i] != ERR_NONE) && !cap_err) begin
          cap_err   = 1'b1;
          cap_code  = ch_code[i];
          cap_order = ch_order[i];
        end
      end
    end
  end

  // Error arbitration and counters: capture errors outrank drain errors.
  always_comb begin
    err_now   = cap_err || drn_err;
    err_code  = cap_err ? cap_code : ERR_MISMATCH;
    err_order = cap_err ? cap_order : drn_order;
    fail_d    = fail_q;
    code_d    = code_q;
    ford_d    = ford_q;
    if (enable && !fail_q && err_now) begin
      fail_d = 1'b1;
      code_d = err_code;
      ford_d = err_order;
    end
    cnt_d  = cnt_q + 32'(n_drain);
    pend_d = pend_q + n_cap - n_drain;
  end

  // Control and reporting state, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_order_q <= '0;
      have_prev_q <= 1'b0;
      fail_q      <= 1'b0;
      code_q      <= ERR_NONE;
      ford_q      <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
    end else begin
      exp_order_q <= exp_order_d;
      have_prev_q <= have_prev_d;
      fail_q      <= fail_d;
      code_q      <= code_d;
      ford_q      <= ford_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
    end
  end

  // Last drained target PC; only consulted once have_prev is set.
  always_ff @(posedge clock) begin
    last_wdata_q <= last_wdata_d;
  end

`ifdef FORMAL
  // No error may be observed while checking is armed.
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!(enable && err_now));
    end
  end
`endif

  assign fail        = fail_q;
  assign fail_code   = code_q;
  assign fail_order  = ford_q;
  assign checked_cnt = cnt_q;
  assign pending     = pend_q;

endmodule

// File: tb/tb_rvfi_pc_order_check.sv
// Bench for rvfi_pc_order_check (NRET=2, DEPTH=8, IALIGN=32): directed
// scenarios followed by randomized traffic, all checked against a reference
// model that tracks outstanding retirements in an associative array keyed by
// rvfi_order.
module tb_rvfi_pc_order_check;

  localparam int XLEN   = 32;
  localparam int NRET   = 2;
  localparam int DEPTH  = 8;
  localparam int IALIGN = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;

  logic [NRET-1:0] v;
  logic [63:0]     o [NRET];
  logic [31:0]     r [NRET];
  logic [31:0]     w [NRET];
  logic [NRET-1:0] in;

  logic [NRET*64-1:0]   order_bus;
  logic [NRET*XLEN-1:0] rdata_bus, wdata_bus;

  logic        fail;
  logic [2:0]  fail_code;
  logic [63:0] fail_order;
  logic [31:0] checked_cnt;
  logic [3:0]  pending;

  assign order_bus = {o[1], o[0]};
  assign rdata_bus = {r[1], r[0]};
  assign wdata_bus = {w[1], w[0]};

  rvfi_pc_order_check #(
    .XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH), .IALIGN(IALIGN)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .rvfi_valid    (v),
    .rvfi_order    (order_bus),
    .rvfi_pc_rdata (rdata_bus),
    .rvfi_pc_wdata (wdata_bus),
    .rvfi_intr     (in),
    .fail          (fail),
    .fail_code     (fail_code),
    .fail_order    (fail_order),
    .checked_cnt   (checked_cnt),
    .pending       (pending)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  typedef struct packed {
    logic [31:0] r;
    logic [31:0] w;
    logic        i;
  } ent_t;

  ent_t            m_buf [longint unsigned];
  longint unsigned m_exp;
  logic [31:0]     m_lw;
  bit              m_hp;
  bit              m_fail;
  logic [2:0]      m_code;
  logic [63:0]     m_ford;
  logic [31:0]     m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_exp  = 0;
    m_lw   = '0;
    m_hp   = 0;
    m_fail = 0;
    m_code = '0;
    m_ford = '0;
    m_cnt  = '0;
  endtask

  // One clock edge of the checker: drain first (entries present before the
  // edge), then classify captures against the updated window.
  task automatic model_edge();
    bit          go, derr, cerr, busy, same;
    logic [63:0] dord, cord;
    logic [2:0]  ccode, code;
    ent_t        e;
    go = 1; derr = 0; cerr = 0; dord = '0; cord = '0; ccode = '0;
    for (int k = 0; k < NRET; k++) begin
      if (go) begin
        if (m_buf.exists(m_exp)) begin
          e = m_buf[m_exp];
          if (m_hp && !e.i && e.r != m_lw && !derr) begin
            derr = 1;
            dord = m_exp;
          end
          m_lw = e.w;
          m_hp = 1;
          m_buf.delete(m_exp);
          m_exp++;
          m_cnt++;
        end else begin
          go = 0;
        end
      end
    end
    for (int ch = 0; ch < NRET; ch++) begin
      if (v[ch]) begin
        busy = 0;
        foreach (m_buf[key]) if ((key % DEPTH) == (o[ch] % DEPTH)) busy = 1;
        same = 0;
        for (int j = 0; j < ch; j++) if (v[j] && o[j] == o[ch]) same = 1;
        code = 3'd0;
        if (o[ch] < m_exp || busy || same) code = 3'd2;
        else if (o[ch] >= m_exp + DEPTH) code = 3'd3;
        else begin
          if (w[ch][1:0] != 2'b00) code = 3'd4;
          m_buf[o[ch]] = '{r: r[ch], w: w[ch], i: in[ch]};
        end
        if (code != 3'd0 && !cerr) begin
          cerr = 1;
          ccode = code;
          cord = o[ch];
        end
      end
    end
    if (enable && !m_fail && (cerr || derr)) begin
      m_fail = 1;
      m_code = cerr ? ccode : 3'd1;
      m_ford = cerr ? cord : dord;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ":fail"},    64'(fail),        64'(m_fail));
    check({tag, ":code"},    64'(fail_code),   64'(m_code));
    check({tag, ":order"},   fail_order,       m_ford);
    check({tag, ":checked"}, 64'(checked_cnt), 64'(m_cnt));
    check({tag, ":pending"}, 64'(pending),     64'(m_buf.num()));
  endtask

  task automatic set_ch(input int ch, input logic [63:0] oo, input logic [31:0] rr,
                        input logic [31:0] ww, input logic ii);
    v[ch]  = 1'b1;
    o[ch]  = oo;
    r[ch]  = rr;
    w[ch]  = ww;
    in[ch] = ii;
  endtask

  task automatic cyc(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    compare_all(tag);
    v  = '0;
    in = '0;
  endtask

  // Asynchronous reset assertion mid-cycle; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #2;
    check({tag, ":rst_fail"},    64'(fail),        64'd0);
    check({tag, ":rst_code"},    64'(fail_code),   64'd0);
    check({tag, ":rst_order"},   fail_order,       64'd0);
    check({tag, ":rst_checked"}, 64'(checked_cnt), 64'd0);
    check({tag, ":rst_pending"}, 64'(pending),     64'd0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned oo;
    logic [31:0]     rr, ww;
    logic            ii;
    bit              skip;

    v = '0; in = '0;
    for (int ch = 0; ch < NRET; ch++) begin
      o[ch] = '0; r[ch] = '0; w[ch] = '0;
    end
    model_reset();
    #1;
    enable = 1'b1;
    do_reset("init");

    // In-order stream 0x0 -> 0x4 -> 0x8
    set_ch(0, 64'd0, 32'h0, 32'h4, 1'b0); cyc("t1a");
    set_ch(0, 64'd1, 32'h4, 32'h8, 1'b0); cyc("t1b");
    set_ch(0, 64'd2, 32'h8, 32'hC, 1'b0); cyc("t1c");
    cyc("t1d");
    check("t1_checked", 64'(checked_cnt), 64'd3);
    check("t1_fail",    64'(fail),        64'd0);
    check("t1_pending", 64'(pending),     64'd0);

    // Order 1 before order 0
    do_reset("t2");
    set_ch(0, 64'd1, 32'h4, 32'h8, 1'b0); cyc("t2a");
    check("t2_pending1", 64'(pending), 64'd1);
    set_ch(0, 64'd0, 32'h0, 32'h4, 1'b0); cyc("t2b");
    cyc("t2c");
    check("t2_checked", 64'(checked_cnt), 64'd2);
    check("t2_pending", 64'(pending),     64'd0);
    check("t2_fail",    64'(fail),        64'd0);

    // Discontinuity at order 2 (last_wdata 0x8, pc_rdata 0x10)
    set_ch(0, 64'd2, 32'h10, 32'h14, 1'b0); cyc("t3a");
    cyc("t3b");
    check("t3_fail",  64'(fail),      64'd1);
    check("t3_code",  64'(fail_code), 64'd1);
    check("t3_order", fail_order,     64'd2);
    set_ch(0, 64'd3, 32'h14, 32'h18, 1'b0); cyc("t3c");
    cyc("t3d");
    check("t3_code_kept", 64'(fail_code),   64'd1);
    check("t3_checked",   64'(checked_cnt), 64'd4);

    // Out of window
    do_reset("t4w");
    set_ch(0, 64'd8, 32'h0, 32'h4, 1'b0); cyc("t4w");
    check("t4w_code",    64'(fail_code), 64'd3);
    check("t4w_order",   fail_order,     64'd8);
    check("t4w_pending", 64'(pending),   64'd0);

    // Same order on both channels
    do_reset("t4d");
    set_ch(0, 64'd3, 32'hC, 32'h10, 1'b0);
    set_ch(1, 64'd3, 32'hC, 32'h10, 1'b0); cyc("t4d");
    check("t4d_code",    64'(fail_code), 64'd2);
    check("t4d_order",   fail_order,     64'd3);
    check("t4d_pending", 64'(pending),   64'd1);

    // Misaligned target
    do_reset("t5a");
    set_ch(0, 64'd0, 32'h0, 32'h102, 1'b0); cyc("t5a");
    check("t5a_code",    64'(fail_code), 64'd4);
    check("t5a_pending", 64'(pending),   64'd1);

    // Trap entry with discontinuous PC
    do_reset("t5b");
    set_ch(0, 64'd0, 32'h0, 32'h4, 1'b0); cyc("t5b1");
    set_ch(0, 64'd1, 32'h200, 32'h204, 1'b1); cyc("t5b2");
    cyc("t5b3");
    check("t5b_fail",    64'(fail),        64'd0);
    check("t5b_checked", 64'(checked_cnt), 64'd2);

    // Mismatch while disarmed
    do_reset("t5c");
    enable = 1'b0;
    set_ch(0, 64'd0, 32'h0, 32'h4, 1'b0); cyc("t5c1");
    set_ch(0, 64'd1, 32'h40, 32'h44, 1'b0); cyc("t5c2");
    cyc("t5c3");
    check("t5c_fail",    64'(fail),        64'd0);
    check("t5c_checked", 64'(checked_cnt), 64'd2);
    enable = 1'b1;

    // Reset with three pending entries, then a fresh order 0
    do_reset("t6");
    set_ch(0, 64'd1, 32'h4, 32'h8, 1'b0);
    set_ch(1, 64'd2, 32'h8, 32'hC, 1'b0); cyc("t6a");
    set_ch(0, 64'd3, 32'hC, 32'h10, 1'b0); cyc("t6b");
    check("t6_pending3", 64'(pending), 64'd3);
    do_reset("t6r");
    set_ch(0, 64'd0, 32'h500, 32'h4, 1'b0); cyc("t6c");
    cyc("t6d");
    check("t6_fail",    64'(fail),        64'd0);
    check("t6_checked", 64'(checked_cnt), 64'd1);
    check("t6_pending", 64'(pending),     64'd0);

    // Slot freed and re-captured on the same edge
    do_reset("t7");
    set_ch(0, 64'd0, 32'h0, 32'h4, 1'b0); cyc("t7a");
    set_ch(0, 64'd8, 32'h20, 32'h24, 1'b0); cyc("t7b");
    check("t7_fail",    64'(fail),    64'd0);
    check("t7_pending", 64'(pending), 64'd1);

    // Randomized traffic
    for (int c = 0; c < 360; c++) begin
      if (c % 30 == 0) begin
        do_reset("rnd");
        enable = ($urandom_range(0, 9) != 0);
      end
      for (int ch = 0; ch < NRET; ch++) begin
        if ($urandom_range(0, 99) < 65) begin
          oo = m_exp + 64'($urandom_range(0, 7));
          if ($urandom_range(0, 49) == 0) oo = oo + DEPTH;
          if ($urandom_range(0, 49) == 0 && m_exp >= 1) oo = m_exp - 1;
          skip = 0;
          if ((m_buf.exists(oo) || (ch == 1 && v[0] && o[0] == oo)) &&
              $urandom_range(0, 19) != 0) skip = 1;
          if (!skip) begin
            rr = 32'(oo * 4);
            ww = 32'((oo + 1) * 4);
            if ($urandom_range(0, 49) == 0) rr = rr ^ 32'h40;
            if ($urandom_range(0, 59) == 0) ww = ww | 32'h2;
            ii = ($urandom_range(0, 19) == 0);
            if (ii) rr = $urandom;
            set_ch(ch, oo, rr, ww, ii);
          end
        end
      end
      cyc("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
